pipelined_alu: RTL and testbench
================================

Name: pipelined_alu

Overview:
- Parametrised-width ALU with a registered output stage and valid/ready handshakes on input and output.
- Single-cycle logic and arithmetic ops complete with 1-cycle latency.
- A multi-cycle shift-add multiply produces the full 2*WIDTH product.
- Sits in the datapath execute stage as the generalised, sequential successor of the fixed 16-bit carry-lookahead ALU; exports zero, cout, overflow and set flags.

Parameters:
- WIDTH, 32, operand and result width in bits; legal values are multiples of 4, from 4 to 64.
- MUL_CYC, WIDTH, number of multiply iterations: one product bit per cycle.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operands and op presented
- in_ready  out  1  block can accept a new operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation select
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  result; low half of the product for MUL
- result_hi  out  WIDTH  high half of the product for MUL; 0 for all other ops
- cout  out  1  carry out of the MSB (ADD/SUB/SLT), else 0
- overflow  out  1  signed overflow (ADD/SUB), else 0
- set  out  1  signed a<b, computed for every op
- zero  out  1  result == 0; for MUL, the full 2*WIDTH product == 0
- err  out  1  unsupported op (see optional feature)

Behaviour:
- Reset, asynchronous, active-high:
  - State goes to IDLE.
  - out_valid=0, result=0, result_hi=0, all flags 0, err=0.
  - Multiplier counter and accumulator cleared.
  - An in-flight multiply is abandoned with no output.
- Op encoding:
  - 000 AND, 001 OR, 010 ADD, 011 MUL, 100 NOR, 101 XOR, 110 SUB, 111 SLT.
- Arithmetic rules:
  - SUB is a + ~b + 1.
  - SLT returns result = {WIDTH-1 zeros, set}, where set = sign(a-b) XOR overflow(a-b).
  - cout and overflow come from the same adder.
  - MUL is unsigned; product = a*b, 2*WIDTH bits, never truncated.
- States:
  - IDLE: no output pending, in_ready=1.
  - MUL: multiplying, in_ready=0.
  - HOLD: result pending, out_valid=1.
- Transitions:
  - IDLE + accept of a non-MUL op: register result and flags, go to HOLD next cycle (latency 1).
  - IDLE + accept of MUL: latch a and b, go to MUL, counter=0.
  - MUL: each cycle, if multiplier bit[cnt] is set, add a<<cnt into the accumulator; cnt++.
  - MUL exit: after MUL_CYC cycles go to HOLD. Latency from accept to out_valid is MUL_CYC+1 cycles.
  - HOLD + out_ready: if in_valid and op!=MUL, accept the new op in the same cycle and stay in HOLD with the new result (back-to-back throughput 1/cycle). If in_valid with MUL, go to MUL. Otherwise go to IDLE.
  - HOLD without out_ready: result, flags and out_valid held stable; in_ready=0.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational from out_ready; there is no combinational path from in_valid.
- a, b and op are sampled only on accept (in_valid & in_ready); changes at other times are ignored.
- Boundary cases:
  - a=b=2^WIDTH-1 for MUL gives the full product with no truncation.
  - ADD of most-negative + most-negative sets overflow=1 and cout=1.
  - Reset asserted in any state returns to IDLE within the same cycle (asynchronous).

Optional Feature:
- Macro: PIPELINED_ALU_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined:
  - Op 011 completes in 1 cycle with result=0, result_hi=0, all flags 0, err=1.
  - The MUL state and multiplier logic are removed.
  - err is 0 for every other op.

Decomposition:
- Package alu_pkg: op-code localparams (OP_AND … OP_SLT) and the state encoding (S_IDLE, S_MUL, S_HOLD).
- Sub-module alu_shift_mul: sequential shift-add multiplier.
  - Ports: clk, rst, start, a, b, busy, done, product[2*WIDTH-1:0].
  - Instantiated only under PIPELINED_ALU_MUL_EN.
- The combinational op mux and flag logic stay in the top module.

Test Plan:
1. WIDTH=32, ADD a=0x7FFFFFFF, b=1, out_ready=1 -> one cycle later: result=0x80000000, overflow=1, cout=0, zero=0.
2. SUB a=5, b=5, then SLT a=0xFFFFFFFF (-1), b=1 on consecutive cycles -> result=0 with zero=1 and cout=1; next cycle result=1 with set=1. in_ready stays high throughout.
3. MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> in_ready=0 for 32 cycles; out_valid on cycle 33 with result=0x00000001, result_hi=0xFFFFFFFE.
4. AND a=0xF0F0F0F0, b=0xFF00FF00 with out_ready=0 for 5 cycles -> result=0xF000F000 held stable, in_ready=0; the transfer occurs on the cycle out_ready rises.
5. Assert rst at cycle 10 of a MUL -> out_valid=0 and all outputs 0 immediately; next op ADD 2+3 returns 5 with no stale product.
6. Build without PIPELINED_ALU_MUL_EN, MUL a=3, b=4 -> one cycle later: err=1, result=0, result_hi=0; a following OR 1|2 returns 3 with err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code values and controller state encoding for pipelined_alu.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_shift_mul.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Full product is presented combinationally on the cycle done is high.
module alu_shift_mul #(
    parameter int WIDTH   = 32,
    parameter int MUL_CYC = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(MUL_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYC - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // The final partial product is folded in combinationally so the top can
    // capture the full result on the same edge as the last iteration.
    always_comb begin
        product = mplier[0] ? (acc + mcand) : acc;
        done    = busy && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Execute-stage ALU with registered result, valid/ready in and out; 1-cycle ops, MUL_CYC+1-cycle MUL.
// Multiplier present only when PIPELINED_ALU_MUL_EN is defined; otherwise op 011 returns err=1.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_CYC = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             overflow,
    output logic             set,
    output logic             zero,
    output logic             err
);

    if ((WIDTH % 4 != 0) || (WIDTH < 4) || (WIDTH > 64) || (MUL_CYC < 1)) begin : g_bad_cfg
        $error("pipelined_alu: unsupported WIDTH or MUL_CYC");
    end

    state_t state, state_nxt;

    logic             accept;
    logic             is_mul;
    logic             take_single;
    logic             take_mul;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_set;
    logic             alu_err;
    logic             alu_zero;

    assign accept      = in_valid & in_ready;
    assign take_single = accept & ~is_mul;
    assign take_mul    = accept & is_mul;

`ifdef PIPELINED_ALU_MUL_EN
    logic                 mul_busy;
    logic                 mul_done;
    logic                 mul_finish;
    logic                 mul_set;
    logic [2*WIDTH-1:0]   mul_product;

    assign is_mul     = (op == OP_MUL);
    assign mul_finish = (state == S_MUL) & mul_busy & mul_done;

    alu_shift_mul #(
        .WIDTH   (WIDTH),
        .MUL_CYC (MUL_CYC)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (take_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The signed compare flag is reported for MUL too, so capture it at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_set <= 1'b0;
        end else if (take_mul) begin
            mul_set <= slt;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
        slt     = sub_sum[WIDTH-1] ^ sub_ovf;
    end

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_set  = slt;
        alu_err  = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_XOR: alu_res = a ^ b;
            OP_ADD: begin
                alu_res  = add_sum[WIDTH-1:0];
                alu_cout = add_sum[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SUB: begin
                alu_res  = sub_sum[WIDTH-1:0];
                alu_cout = sub_sum[WIDTH];
                alu_ovf  = sub_ovf;
            end
            OP_SLT: begin
                alu_res  = {{(WIDTH-1){1'b0}}, slt};
                alu_cout = sub_sum[WIDTH];
            end
            // Only OP_MUL lands here, and only as a single-cycle op when the
            // multiplier is absent.
            default: begin
                alu_set = 1'b0;
                alu_err = 1'b1;
            end
        endcase
        alu_zero = ~alu_err & (alu_res == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HOLD: begin
                if (take_mul) begin
                    state_nxt = S_MUL;
                end else if (take_single) begin
                    state_nxt = S_HOLD;
                end else if ((state == S_HOLD) && out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
`ifdef PIPELINED_ALU_MUL_EN
            S_MUL: begin
                if (mul_finish) begin
                    state_nxt = S_HOLD;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
        out_valid = (state == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            set       <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (take_single) begin
            result    <= alu_res;
            result_hi <= '0;
            cout      <= alu_cout;
            overflow  <= alu_ovf;
            set       <= alu_set;
            zero      <= alu_zero;
            err       <= alu_err;
        end
`ifdef PIPELINED_ALU_MUL_EN
        else if (mul_finish) begin
            result    <= mul_product[WIDTH-1:0];
            result_hi <= mul_product[2*WIDTH-1:WIDTH];
            cout      <= 1'b0;
            overflow  <= 1'b0;
            set       <= mul_set;
            zero      <= (mul_product == '0);
            err       <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Randomised scoreboard bench for pipelined_alu (WIDTH=32), with directed corner cases.
module tb_pipelined_alu;

    localparam int W = 32;
`ifdef PIPELINED_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cout;
        logic         ovf;
        logic         set;
        logic         zero;
        logic         err;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         cout, overflow, set, zero, err;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    rdy_pct = 100;
    bit    seen = 0;
    bit    stalled = 0;
    resp_t held;
    resp_t exp_q[$];
    int    cyc_q[$];
    int    lat_q[$];

    pipelined_alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .overflow  (overflow),
        .set       (set),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Reference model: plain integer arithmetic on the op's definition.
    function automatic resp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        resp_t r;
        longint sx, sy, s, maxs, mins;
        longint unsigned ux, uy, p;
        r    = '0;
        p    = 0;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        ux   = {32'd0, x};
        uy   = {32'd0, y};
        maxs = (longint'(1) << (W - 1)) - 1;
        mins = -(longint'(1) << (W - 1));
        r.set = (sx < sy);
        case (o)
            3'd0: r.res = x & y;
            3'd1: r.res = x | y;
            3'd4: r.res = ~(x | y);
            3'd5: r.res = x ^ y;
            3'd2: begin
                s      = sx + sy;
                r.res  = W'(ux + uy);
                r.cout = ((ux + uy) >> W) != 0;
                r.ovf  = (s > maxs) || (s < mins);
            end
            3'd6: begin
                s      = sx - sy;
                r.res  = x - y;
                r.cout = (x >= y);
                r.ovf  = (s > maxs) || (s < mins);
            end
            3'd7: begin
                r.res  = {{(W-1){1'b0}}, r.set};
                r.cout = (x >= y);
            end
            default: begin
                if (MUL_EN) begin
                    p     = ux * uy;
                    r.res = p[W-1:0];
                    r.hi  = p[2*W-1:W];
                end else begin
                    r.set = 1'b0;
                    r.err = 1'b1;
                end
            end
        endcase
        if (!r.err) r.zero = (o == 3'd3) ? (p == 0) : (r.res == '0);
        return r;
    endfunction

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(o, x, y));
                cyc_q.push_back(cyc);
                lat_q.push_back((o == 3'd3 && MUL_EN) ? W + 1 : 1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout op=%0d in_ready=%b required accept within 300 cycles", o, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            op       = 3'($urandom);
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({out_valid, result, result_hi, cout, overflow, set, zero, err} !== '0) begin
            errors++;
            $display("FAIL %s outputs got v=%b r=%h hi=%h c=%b o=%b s=%b z=%b e=%b required all 0",
                     name, out_valid, result, result_hi, cout, overflow, set, zero, err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready got %b required 1", name, in_ready);
        end
    endtask

    task automatic mid_reset;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        cyc_q.delete();
        lat_q.delete();
        seen    = 0;
        stalled = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    // Monitor: checks handshake rules, latency and stability, and pops on transfer.
    initial begin
        resp_t cur, ex;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cur = '{result, result_hi, cout, overflow, set, zero, err};
                if (stalled) begin
                    checks++;
                    if (!out_valid || cur !== held) begin
                        errors++;
                        $display("FAIL hold_stable got v=%b %h required v=1 %h", out_valid, cur, held);
                    end
                end
                if (out_valid) begin
                    checks++;
                    if (in_ready !== out_ready) begin
                        errors++;
                        $display("FAIL in_ready_hold got %b required %b", in_ready, out_ready);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got %h required no output", cur);
                    end else begin
                        if (!seen) begin
                            checks++;
                            if (cyc - cyc_q[0] != lat_q[0]) begin
                                errors++;
                                $display("FAIL latency got %0d required %0d", cyc - cyc_q[0], lat_q[0]);
                            end
                            seen = 1;
                        end
                        if (out_ready) begin
                            ex = exp_q.pop_front();
                            void'(cyc_q.pop_front());
                            void'(lat_q.pop_front());
                            seen = 0;
                            checks++;
                            if (cur !== ex) begin
                                errors++;
                                $display("FAIL resp got res=%h hi=%h c=%b o=%b s=%b z=%b e=%b required res=%h hi=%h c=%b o=%b s=%b z=%b e=%b",
                                         cur.res, cur.hi, cur.cout, cur.ovf, cur.set, cur.zero, cur.err,
                                         ex.res, ex.hi, ex.cout, ex.ovf, ex.set, ex.zero, ex.err);
                            end
                        end
                    end
                end
                stalled = out_valid && !out_ready;
                held    = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Overflow into the sign bit, then most-negative + most-negative.
        send(3'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        send(3'd2, 32'h8000_0000, 32'h8000_0000);
        idle(2);

        // Back-to-back SUB then SLT.
        send(3'd6, 32'd5, 32'd5);
        send(3'd7, 32'hFFFF_FFFF, 32'd1);
        idle(2);

        // Full-width MUL corner.
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(2);

        // Output stalled for 5 cycles with a new op waiting behind it.
        rdy_pct = 0;
        idle(1);
        send(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        idle(5);
        rdy_pct = 100;
        idle(2);

        // Reset mid-operation, then a clean ADD.
        send(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        rdy_pct = 0;
        idle(9);
        mid_reset();
        rdy_pct = 100;
        send(3'd2, 32'd2, 32'd3);
        idle(2);

        // MUL 3*4 followed by OR.
        send(3'd3, 32'd3, 32'd4);
        send(3'd1, 32'd1, 32'd2);
        idle(2);

        rdy_pct = 70;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(7)), pick(), pick());
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
        end

        rdy_pct = 100;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
